// File: rtl/pipe_pkg.sv
// Shared pipeline definitions used by the arbiter and the per-pipeline instruction queues.
package pipe_pkg;

  localparam int INSTR_W    = 32;
  localparam int FIFO_DEPTH = 8;
  localparam int FIFO_AF    = 6;

  typedef logic [INSTR_W-1:0] instr_t;

endpackage

// File: rtl/instr_fifo_ptr.sv
// Wrap-bit pointer register: the MSB toggles each time the address bits roll over.
module instr_fifo_ptr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_r;

  // Pointer state: clear wins over increment, and the natural overflow of W bits does the wrap.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      ptr_r <= {W{1'b0}};
    end else if (inc) begin
      ptr_r <= ptr_r + W'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/instr_fifo.sv
// First-word-fall-through instruction queue between the arbiter and one pipeline's decode stage.
module instr_fifo
  import pipe_pkg::*;
#(
  parameter int DEPTH    = FIFO_DEPTH,
  parameter int WIDTH    = INSTR_W,
  parameter int AF_LEVEL = FIFO_AF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_instr,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_instr,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_s;
  logic [PW-1:0]    rd_ptr_s;
  logic [PW-1:0]    count_s;
  logic             empty_s;
  logic             full_s;
  logic             push_s;
  logic             pop_s;
  logic             overflow_r;

  instr_fifo_ptr #(.W(PW)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (push_s),
    .ptr   (wr_ptr_s)
  );

  instr_fifo_ptr #(.W(PW)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (pop_s),
    .ptr   (rd_ptr_s)
  );

  // Status is a pure function of the registered pointers, so nothing on in_* reaches out_* in the same cycle.
  assign empty_s = (wr_ptr_s == rd_ptr_s);
  assign full_s  = (wr_ptr_s[AW-1:0] == rd_ptr_s[AW-1:0]) && (wr_ptr_s[AW] != rd_ptr_s[AW]);
  assign count_s = wr_ptr_s - rd_ptr_s;

  // No full-bypass: a pop in the same cycle does not free a slot for the push.
  assign push_s = in_valid && !full_s && !flush;
  assign pop_s  = !empty_s && out_ready && !flush;

  // Entry storage; contents survive pops and are simply overwritten later.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_s[AW-1:0]] <= in_instr;
    end
  end

  // Sticky record of any attempt to push into a full queue; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (in_valid && full_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  // Head entry presented to decode, forced to zero while the queue is empty.
  always_comb begin
    out_instr = {WIDTH{1'b0}};
    if (!empty_s) begin
      out_instr = mem_r[rd_ptr_s[AW-1:0]];
    end else begin
      out_instr = {WIDTH{1'b0}};
    end
  end

  assign in_ready    = !full_s;
  assign out_valid   = !empty_s;
  assign count       = count_s;
  assign almost_full = (count_s >= PW'(AF_LEVEL));
  assign overflow    = overflow_r;

endmodule

// File: tb/tb_instr_fifo.sv
// Directed self-checking bench for instr_fifo with hand-computed expectations per scenario.
module tb_instr_fifo;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic        out_ready;
  logic [3:0]  count;
  logic        almost_full;
  logic        overflow;

  int tests;
  int fails;

  instr_fifo #(.DEPTH(8), .WIDTH(32), .AF_LEVEL(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_instr    (in_instr),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_ready   (out_ready),
    .count       (count),
    .almost_full (almost_full),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_instr = base + 32'(i);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'h0; out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    tests++; if (out_instr !== 32'h0) begin fails++; $display("FAIL reset_out_instr got=%h exp=0", out_instr); end
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", count); end
    tests++; if (almost_full !== 1'b0) begin fails++; $display("FAIL reset_af got=%0b exp=0", almost_full); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
  endtask

  task automatic test_basic();
    in_valid = 1'b1; in_instr = 32'h0004_5678;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_no_comb_path got=%0b exp=0", out_valid); end
    step();
    in_instr = 32'h0005_678A;
    step();
    in_valid = 1'b0;
    tests++; if (count !== 4'd2) begin fails++; $display("FAIL basic_count got=%0d exp=2", count); end
    tests++; if (out_instr !== 32'h0004_5678) begin fails++; $display("FAIL basic_head got=%h exp=00045678", out_instr); end
    out_ready = 1'b1;
    step();
    tests++; if (out_instr !== 32'h0005_678A) begin fails++; $display("FAIL basic_second got=%h exp=0005678a", out_instr); end
    step();
    out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_empty_valid got=%0b exp=0", out_valid); end
    tests++; if (out_instr !== 32'h0) begin fails++; $display("FAIL basic_empty_instr got=%h exp=0", out_instr); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_instr = 32'h0000_00A0 + 32'(i);
      step();
      if (i == 4) begin
        tests++; if (almost_full !== 1'b0) begin fails++; $display("FAIL fill_af_at5 got=%0b exp=0", almost_full); end
      end
      if (i == 5) begin
        tests++; if (almost_full !== 1'b1) begin fails++; $display("FAIL fill_af_at6 got=%0b exp=1", almost_full); end
      end
    end
    in_valid = 1'b0;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL fill_in_ready got=%0b exp=0", in_ready); end
    tests++; if (count !== 4'd8) begin fails++; $display("FAIL fill_count got=%0d exp=8", count); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL fill_ovf_before got=%0b exp=0", overflow); end
    in_valid = 1'b1; in_instr = 32'hDEAD_BEEF;
    step();
    in_valid = 1'b0;
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL fill_ovf_set got=%0b exp=1", overflow); end
    tests++; if (count !== 4'd8) begin fails++; $display("FAIL fill_count_after got=%0d exp=8", count); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (out_instr !== 32'h0000_00A0 + 32'(i)) begin
        fails++; $display("FAIL fill_drain[%0d] got=%h exp=%h", i, out_instr, 32'h0000_00A0 + 32'(i));
      end
      step();
    end
    out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fill_drained_valid got=%0b exp=0", out_valid); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] exp_q[$];
    logic [31:0] nxt;
    push_words(32'h0000_00B0, 3);
    exp_q = '{32'h0000_00B0, 32'h0000_00B1, 32'h0000_00B2};
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      nxt = 32'h1111_1111 + 32'(i);
      in_instr = nxt;
      tests++;
      if (out_instr !== exp_q[0] || count !== 4'd3) begin
        fails++; $display("FAIL simul[%0d] got=%h/%0d exp=%h/3", i, out_instr, count, exp_q[0]);
      end
      step();
      void'(exp_q.pop_front());
      exp_q.push_back(nxt);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (out_instr !== exp_q[0]) begin fails++; $display("FAIL simul_drain[%0d] got=%h exp=%h", i, out_instr, exp_q[0]); end
      step();
      void'(exp_q.pop_front());
    end
    out_ready = 1'b0;
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL simul_end_count got=%0d exp=0", count); end
  endtask

  task automatic test_full_pushpop();
    reset = 1'b1;
    step();
    reset = 1'b0;
    push_words(32'h0000_00F0, 8);
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL fullpp_ovf_before got=%0b exp=0", overflow); end
    in_valid = 1'b1; in_instr = 32'hDEAD_0001; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    tests++; if (count !== 4'd7) begin fails++; $display("FAIL fullpp_count got=%0d exp=7", count); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL fullpp_ovf got=%0b exp=1", overflow); end
    out_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      tests++;
      if (out_instr !== 32'h0000_00F0 + 32'(i)) begin
        fails++; $display("FAIL fullpp_drain[%0d] got=%h exp=%h", i, out_instr, 32'h0000_00F0 + 32'(i));
      end
      step();
    end
    out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fullpp_empty got=%0b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    push_words(32'h0000_00C0, 5);
    tests++; if (count !== 4'd5) begin fails++; $display("FAIL flush_pre_count got=%0d exp=5", count); end
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h0000_0C99; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL flush_count got=%0d exp=0", count); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got=%0b exp=0", out_valid); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL flush_ovf got=%0b exp=1", overflow); end
    in_valid = 1'b1; in_instr = 32'h000A_BCDE;
    step();
    in_valid = 1'b0;
    tests++; if (out_instr !== 32'h000A_BCDE) begin fails++; $display("FAIL flush_first got=%h exp=000abcde", out_instr); end
    tests++; if (count !== 4'd1) begin fails++; $display("FAIL flush_post_count got=%0d exp=1", count); end
  endtask

  task automatic test_reset_mid();
    push_words(32'h0000_00D0, 3);
    tests++; if (count !== 4'd4 || overflow !== 1'b1) begin fails++; $display("FAIL rstmid_pre got=%0d/%0b exp=4/1", count, overflow); end
    reset = 1'b1; flush = 1'b1; in_valid = 1'b1; in_instr = 32'h0000_0D99; out_ready = 1'b1;
    step();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rstmid_in_ready got=%0b exp=1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_out_valid got=%0b exp=0", out_valid); end
    tests++; if (out_instr !== 32'h0) begin fails++; $display("FAIL rstmid_out_instr got=%h exp=0", out_instr); end
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL rstmid_count got=%0d exp=0", count); end
    tests++; if (almost_full !== 1'b0) begin fails++; $display("FAIL rstmid_af got=%0b exp=0", almost_full); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL rstmid_ovf got=%0b exp=0", overflow); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_fill_overflow();
    test_simultaneous();
    test_full_pushpop();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
